// File: rtl/vga_pixel_sink.sv
// VGA raster generator and pixel sink: produces pixelX/pixelY for the drawing units and
// drives DAC colour and syncs, with syncs delayed to line up with the colour pipeline.
module vga_pixel_sink #(
  parameter int CLK_DIV    = 2,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 2,
  parameter int SYNC_POL   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  redIn,
  input  logic [7:0]  greenIn,
  input  logic [7:0]  blueIn,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        pixelTick,
  output logic        drawActive,
  output logic        startOfFrame,
  output logic [7:0]  vgaR,
  output logic [7:0]  vgaG,
  output logic [7:0]  vgaB,
  output logic        vgaHS,
  output logic        vgaVS,
  output logic        vgaBlankN
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] X_LAST    = 11'(H_TOTAL - 1);
  localparam logic [10:0] Y_LAST    = 11'(V_TOTAL - 1);
  localparam logic [10:0] HS_START  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [1:0]  DIV_LAST  = 2'(CLK_DIV - 1);
  localparam logic        SYNC_ACT  = (SYNC_POL != 0);

  if (CLK_DIV < 1 || CLK_DIV > 4 || PIPE_DELAY < 1 || PIPE_DELAY > 4 ||
      H_TOTAL >= 2048 || V_TOTAL >= 2048) begin : g_param_check
    $error("vga_pixel_sink: illegal parameter set");
  end

  // Sink contract: no handshake. Colour is sampled only on the clk where pixelTick=1, and
  // must belong to the pixelX/pixelY value presented PIPE_DELAY ticks earlier.

  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } pipe_t;

  logic [1:0]  div_q, div_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic        tick_raw;
  logic        hs_raw, vs_raw, draw_act;
  pipe_t       pipe_q [PIPE_DELAY];
  pipe_t       tail;
  logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
  logic        hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;

  assign tick_raw = (div_q == DIV_LAST);
  assign draw_act = (x_q < 11'(H_ACTIVE)) && (y_q < 11'(V_ACTIVE));
  assign hs_raw   = (x_q >= HS_START) && (x_q < HS_END);
  assign vs_raw   = (y_q >= VS_START) && (y_q < VS_END);
  assign tail     = pipe_q[PIPE_DELAY-1];

  always_comb begin
    div_d = tick_raw ? 2'd0 : div_q + 2'd1;
    x_d   = x_q;
    y_d   = y_q;
    if (tick_raw) begin
      if (x_q == X_LAST) begin
        x_d = 11'd0;
        y_d = (y_q == Y_LAST) ? 11'd0 : y_q + 11'd1;
      end else begin
        x_d = x_q + 11'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= 2'd0;
      x_q   <= 11'd0;
      y_q   <= 11'd0;
    end else begin
      div_q <= div_d;
      x_q   <= x_d;
      y_q   <= y_d;
    end
  end

  // Sync/blank delay line: matches the latency of the drawing units feeding redIn..blueIn.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PIPE_DELAY; i++) pipe_q[i] <= '0;
    end else if (tick_raw) begin
      pipe_q[0] <= {hs_raw, vs_raw, draw_act};
      for (int i = 1; i < PIPE_DELAY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_comb begin
    r_d       = r_q;
    g_d       = g_q;
    b_d       = b_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    blank_n_d = blank_n_q;
    if (tick_raw) begin
      r_d       = tail.act ? redIn   : 8'd0;
      g_d       = tail.act ? greenIn : 8'd0;
      b_d       = tail.act ? blueIn  : 8'd0;
      hs_d      = tail.hs ? SYNC_ACT : ~SYNC_ACT;
      vs_d      = tail.vs ? SYNC_ACT : ~SYNC_ACT;
      blank_n_d = tail.act;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q       <= 8'd0;
      g_q       <= 8'd0;
      b_q       <= 8'd0;
      hs_q      <= ~SYNC_ACT;
      vs_q      <= ~SYNC_ACT;
      blank_n_q <= 1'b0;
    end else begin
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
    end
  end

  assign pixelX       = x_q;
  assign pixelY       = y_q;
  assign pixelTick    = tick_raw && !reset;
  assign drawActive   = draw_act;
  assign startOfFrame = tick_raw && !reset && (x_q == 11'd0) && (y_q == 11'd0);
  assign vgaR         = r_q;
  assign vgaG         = g_q;
  assign vgaB         = b_q;
  assign vgaHS        = hs_q;
  assign vgaVS        = vs_q;
  assign vgaBlankN    = blank_n_q;

endmodule
